// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART transmitter and receiver.
// Holds the baud-timing derivation so both ends agree on the number of
// clocks per bit, the frame shape (8 data bits, 1 stop bit) and the
// receiver FSM state encoding.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  // Receiver FSM state encoding (kept as plain constants for legacy tools).
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

  // Clocks per bit (S); integer divide, remainder discarded.
  function automatic int unsigned bit_ticks(input int unsigned clock_freq,
                                            input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

  // Clocks from a detected start edge to the middle of the start bit (H).
  function automatic int unsigned half_ticks(input int unsigned clock_freq,
                                             input int unsigned baud_rate);
    return bit_ticks(clock_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: byte output side of the UART receiver.
//   data_out        received byte, stable while data_out_valid is high
//   data_out_valid  byte available
//   data_out_ready  consumer accepts the byte together with data_out_valid
//   framing_error   one-cycle pulse, stop bit sampled low
//   overrun         one-cycle pulse, new byte dropped (held byte not taken)
// master: the receiver; slave: the byte consumer.
interface uart_receiver_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data_out;
  logic                 data_out_valid;
  logic                 data_out_ready;
  logic                 framing_error;
  logic                 overrun;

  modport master (
    output data_out, data_out_valid, framing_error, overrun,
    input  data_out_ready
  );

  modport slave (
    input  data_out, data_out_valid, framing_error, overrun,
    output data_out_ready
  );

endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input.
//   clk    destination clock
//   reset  synchronous, active-high; both flops load RESET_VALUE
//   d      asynchronous input
//   q      synchronized output (registered)
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture; the first stage may go metastable, the second settles.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= RESET_VALUE;
      sync_r <= RESET_VALUE;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial-to-parallel receiver with ready/valid output.
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   serial_in  asynchronous RX line, idle high
//   rx_if      byte output (data_out/valid/ready) plus framing_error and
//              overrun one-cycle pulses
// The line is synchronized, the start bit is confirmed at its midpoint,
// and every following bit is sampled one bit period later (mid-bit).
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 125_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            serial_in,
  uart_receiver_if.master rx_if
);

  localparam int unsigned S  = bit_ticks(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned H  = half_ticks(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned CW = $clog2(S);
  // Bit index is sized to count through the whole frame body.
  localparam int unsigned BW = $clog2(DATA_BITS + STOP_BITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(S - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] IDX_ONE  = BW'(1);

  logic                 rx_s;
  logic [2:0]           state_r;
  logic [CW-1:0]        cnt_r;
  logic [BW-1:0]        bit_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] data_r;
  logic                 valid_r;
  logic                 framing_error_r;
  logic                 overrun_r;
  logic                 stop_sample_s;
  logic                 handshake_s;

  sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (serial_in),
    .q     (rx_s)
  );

  assign stop_sample_s = (state_r == ST_STOP) && (cnt_r == CNT_LAST);
  assign handshake_s   = valid_r && rx_if.data_out_ready;

  // Frame FSM with bit-period counter, bit index and shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CW{1'b0}};
      bit_idx_r <= {BW{1'b0}};
      shift_r   <= {DATA_BITS{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r <= {CW{1'b0}};
          if (!rx_s) begin
            state_r <= ST_START;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_START: begin
          if (cnt_r == CNT_HALF) begin
            cnt_r <= {CW{1'b0}};
            // A line back high at mid-start was a glitch, not a frame.
            if (rx_s) begin
              state_r <= ST_IDLE;
            end else begin
              bit_idx_r <= {BW{1'b0}};
              state_r   <= ST_DATA;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r     <= {CW{1'b0}};
            // LSB arrives first; shifting right lands it in bit 0 at the end.
            shift_r   <= {rx_s, shift_r[DATA_BITS-1:1]};
            bit_idx_r <= bit_idx_r + IDX_ONE;
            if (bit_idx_r == IDX_LAST) begin
              state_r <= ST_STOP;
            end else begin
              state_r <= ST_DATA;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r   <= {CW{1'b0}};
            state_r <= rx_s ? ST_IDLE : ST_WAIT_HIGH;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_WAIT_HIGH: begin
          // A break or stuck-low line must go high before a new start counts.
          cnt_r <= {CW{1'b0}};
          if (rx_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT_HIGH;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= {CW{1'b0}};
        end
      endcase
    end
  end

  // Output holding register, valid flag and error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r          <= {DATA_BITS{1'b0}};
      valid_r         <= 1'b0;
      framing_error_r <= 1'b0;
      overrun_r       <= 1'b0;
    end else begin
      framing_error_r <= stop_sample_s && !rx_s;
      overrun_r       <= 1'b0;
      if (stop_sample_s && rx_s) begin
        // A byte taken this very cycle frees the holding register.
        if (!valid_r || handshake_s) begin
          data_r  <= shift_r;
          valid_r <= 1'b1;
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (handshake_s) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign rx_if.data_out       = data_r;
  assign rx_if.data_out_valid = valid_r;
  assign rx_if.framing_error  = framing_error_r;
  assign rx_if.overrun        = overrun_r;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: self-checking bench for uart_receiver at S=10, H=5.
module tb_uart_receiver;

  localparam int unsigned CF       = 1000;
  localparam int unsigned BR       = 100;
  localparam int          S        = CF / BR;
  localparam int          H        = S / 2;
  // Edge offset from the first low capture to the stop-bit sample.
  localparam int          STOP_OFS = 2 + H + 9 * S;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic serial_in = 1'b1;

  uart_receiver_if bus ();

  uart_receiver #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
    .clk       (clk),
    .reset     (reset),
    .serial_in (serial_in),
    .rx_if     (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Posedge counter: after the n-th rising edge cyc == n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation log: bytes at each valid rise, pulse counts and timestamps.
  logic       prev_valid = 1'b0;
  logic [7:0] obs_q[$];
  int rise_cyc = 0;
  int fe_count = 0;
  int fe_cyc   = 0;
  int ov_count = 0;
  int ov_cyc   = 0;

  always @(negedge clk) begin
    prev_valid <= bus.data_out_valid;
    if (bus.data_out_valid && !prev_valid) begin
      obs_q.push_back(bus.data_out);
      rise_cyc <= cyc;
    end
    if (bus.framing_error) begin
      fe_count <= fe_count + 1;
      fe_cyc   <= cyc;
    end
    if (bus.overrun) begin
      ov_count <= ov_count + 1;
      ov_cyc   <= cyc;
    end
  end

  // Drives one 8N1 frame starting now (called just after a falling edge);
  // the line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    serial_in = 1'b0;
    repeat (S) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (S) @(negedge clk);
    end
    serial_in = stop_bit;
    repeat (S) @(negedge clk);
  endtask

  task automatic test_reset();
    n_tests++;
    if (bus.data_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.data_out_valid);
    end
    n_tests++;
    if (bus.data_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_data: got %h expected 00", bus.data_out);
    end
    n_tests++;
    if (bus.framing_error !== 1'b0 || bus.overrun !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses: got fe=%b ov=%b expected 0 0", bus.framing_error, bus.overrun);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.data_out_valid !== 1'b0 || bus.data_out !== 8'h00) begin
      n_fail++; $display("FAIL post_reset_idle: got v=%b d=%h expected 0 00", bus.data_out_valid, bus.data_out);
    end
  endtask

  task automatic test_basic();
    int k, rc0, errs;
    logic [7:0] got;
    bus.data_out_ready = 1'b0;
    rc0 = obs_q.size();
    k = cyc + 1;
    send_frame(8'hA5, 1'b1);
    repeat (2) @(negedge clk);
    n_tests++;
    if (obs_q.size() != rc0 + 1) begin
      n_fail++; $display("FAIL basic_count: got %0d expected %0d", obs_q.size(), rc0 + 1);
    end
    got = 8'h00;
    if (obs_q.size() > rc0) got = obs_q[rc0];
    n_tests++;
    if (got !== 8'hA5) begin
      n_fail++; $display("FAIL basic_data: got %h expected a5", got);
    end
    n_tests++;
    if (rise_cyc != k + STOP_OFS) begin
      n_fail++; $display("FAIL basic_latency: got %0d expected %0d", rise_cyc - k, STOP_OFS);
    end
    errs = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.data_out_valid !== 1'b1 || bus.data_out !== 8'hA5) errs++;
    end
    n_tests++;
    if (errs != 0) begin
      n_fail++; $display("FAIL basic_hold: got %0d bad cycles expected 0", errs);
    end
    bus.data_out_ready = 1'b1;
    @(negedge clk);
    bus.data_out_ready = 1'b0;
    n_tests++;
    if (bus.data_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_accept: got valid=%b expected 0", bus.data_out_valid);
    end
  endtask

  task automatic test_glitch();
    int rc0, fe0, glen;
    bus.data_out_ready = 1'b1;
    rc0 = obs_q.size();
    fe0 = fe_count;
    glen = $urandom_range(1, 4);
    serial_in = 1'b0;
    repeat (glen) @(negedge clk);
    serial_in = 1'b1;
    repeat (30) @(negedge clk);
    n_tests++;
    if (obs_q.size() != rc0 || fe_count != fe0) begin
      n_fail++; $display("FAIL glitch_ignored: got frames=%0d fe=%0d expected 0 0", obs_q.size() - rc0, fe_count - fe0);
    end
    send_frame(8'h3C, 1'b1);
    repeat (3) @(negedge clk);
    n_tests++;
    if (obs_q.size() != rc0 + 1 || obs_q[obs_q.size() - 1] !== 8'h3C) begin
      n_fail++; $display("FAIL glitch_next: got n=%0d last=%h expected 1 3c", obs_q.size() - rc0, obs_q[obs_q.size() - 1]);
    end
  endtask

  task automatic test_framing();
    int k, rc0, fe0, ov0;
    bus.data_out_ready = 1'b1;
    rc0 = obs_q.size();
    fe0 = fe_count;
    ov0 = ov_count;
    k = cyc + 1;
    send_frame(8'h55, 1'b0);
    repeat (30) @(negedge clk);
    serial_in = 1'b1;
    repeat (20) @(negedge clk);
    n_tests++;
    if (fe_count - fe0 != 1) begin
      n_fail++; $display("FAIL framing_pulse: got %0d cycles expected 1", fe_count - fe0);
    end
    n_tests++;
    if (fe_cyc != k + STOP_OFS) begin
      n_fail++; $display("FAIL framing_time: got %0d expected %0d", fe_cyc - k, STOP_OFS);
    end
    n_tests++;
    if (obs_q.size() != rc0 || ov_count != ov0) begin
      n_fail++; $display("FAIL framing_no_byte: got frames=%0d ov=%0d expected 0 0", obs_q.size() - rc0, ov_count - ov0);
    end
    send_frame(8'h0F, 1'b1);
    repeat (3) @(negedge clk);
    n_tests++;
    if (obs_q.size() != rc0 + 1 || obs_q[obs_q.size() - 1] !== 8'h0F) begin
      n_fail++; $display("FAIL framing_next: got n=%0d last=%h expected 1 0f", obs_q.size() - rc0, obs_q[obs_q.size() - 1]);
    end
  endtask

  task automatic test_overrun();
    int k2, rc0, ov0, fe0;
    bus.data_out_ready = 1'b0;
    rc0 = obs_q.size();
    ov0 = ov_count;
    fe0 = fe_count;
    send_frame(8'h11, 1'b1);
    k2 = cyc + 1;
    send_frame(8'h22, 1'b1);
    repeat (3) @(negedge clk);
    n_tests++;
    if (obs_q.size() != rc0 + 1 || obs_q[obs_q.size() - 1] !== 8'h11) begin
      n_fail++; $display("FAIL overrun_first: got n=%0d last=%h expected 1 11", obs_q.size() - rc0, obs_q[obs_q.size() - 1]);
    end
    n_tests++;
    if (ov_count - ov0 != 1 || ov_cyc != k2 + STOP_OFS) begin
      n_fail++; $display("FAIL overrun_pulse: got n=%0d at %0d expected 1 at %0d", ov_count - ov0, ov_cyc - k2, STOP_OFS);
    end
    n_tests++;
    if (bus.data_out !== 8'h11 || bus.data_out_valid !== 1'b1) begin
      n_fail++; $display("FAIL overrun_held: got v=%b d=%h expected 1 11", bus.data_out_valid, bus.data_out);
    end
    n_tests++;
    if (fe_count != fe0) begin
      n_fail++; $display("FAIL overrun_no_fe: got %0d expected 0", fe_count - fe0);
    end
    bus.data_out_ready = 1'b1;
    @(negedge clk);
    bus.data_out_ready = 1'b0;
    n_tests++;
    if (bus.data_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL overrun_accept: got valid=%b expected 0", bus.data_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int k2, ov0;
    bus.data_out_ready = 1'b0;
    ov0 = ov_count;
    send_frame(8'h11, 1'b1);
    k2 = cyc + 1;
    fork
      send_frame(8'h22, 1'b1);
      begin
        while (cyc != k2 + STOP_OFS - 1) @(negedge clk);
        bus.data_out_ready = 1'b1;
        @(negedge clk);
        bus.data_out_ready = 1'b0;
        n_tests++;
        if (bus.data_out_valid !== 1'b1 || bus.data_out !== 8'h22 || bus.overrun !== 1'b0) begin
          n_fail++; $display("FAIL b2b_commit: got v=%b d=%h ov=%b expected 1 22 0", bus.data_out_valid, bus.data_out, bus.overrun);
        end
      end
    join
    repeat (3) @(negedge clk);
    n_tests++;
    if (ov_count != ov0 || bus.data_out !== 8'h22 || bus.data_out_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_hold: got ov=%0d v=%b d=%h expected 0 1 22", ov_count - ov0, bus.data_out_valid, bus.data_out);
    end
    bus.data_out_ready = 1'b1;
    @(negedge clk);
    bus.data_out_ready = 1'b0;
    n_tests++;
    if (bus.data_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept: got valid=%b expected 0", bus.data_out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int k, rc1;
    bus.data_out_ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.data_out_valid !== 1'b1 || bus.data_out !== 8'h5A) begin
      n_fail++; $display("FAIL rmid_held: got v=%b d=%h expected 1 5a", bus.data_out_valid, bus.data_out);
    end
    rc1 = obs_q.size();
    k = cyc + 1;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        while (cyc != k + 2 + H + 3 * S - 3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_tests++;
        if (bus.data_out_valid !== 1'b0 || bus.data_out !== 8'h00 ||
            bus.framing_error !== 1'b0 || bus.overrun !== 1'b0) begin
          n_fail++; $display("FAIL rmid_outputs: got v=%b d=%h fe=%b ov=%b expected 0 00 0 0",
                             bus.data_out_valid, bus.data_out, bus.framing_error, bus.overrun);
        end
      end
    join
    repeat (5) @(negedge clk);
    n_tests++;
    if (obs_q.size() != rc1 || bus.data_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rmid_aborted: got frames=%0d v=%b expected 0 0", obs_q.size() - rc1, bus.data_out_valid);
    end
    bus.data_out_ready = 1'b1;
    send_frame(8'h81, 1'b1);
    repeat (3) @(negedge clk);
    n_tests++;
    if (obs_q.size() != rc1 + 1 || obs_q[obs_q.size() - 1] !== 8'h81) begin
      n_fail++; $display("FAIL rmid_next: got n=%0d last=%h expected 1 81", obs_q.size() - rc1, obs_q[obs_q.size() - 1]);
    end
  endtask

  // Random frames, some with a bad stop bit; the model expects every good
  // frame's byte in order and one framing pulse per bad frame.
  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int rc0, fe0, ov0, fe_exp, errs;
    bit bad;
    bus.data_out_ready = 1'b1;
    rc0 = obs_q.size();
    fe0 = fe_count;
    ov0 = ov_count;
    fe_exp = 0;
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 12)) @(negedge clk);
      b = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 3) == 0);
      send_frame(b, !bad);
      if (bad) begin
        serial_in = 1'b1;
        fe_exp++;
        repeat (S) @(negedge clk);
      end else begin
        exp_q.push_back(b);
      end
    end
    repeat (5) @(negedge clk);
    n_tests++;
    if (obs_q.size() - rc0 != exp_q.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d expected %0d", obs_q.size() - rc0, exp_q.size());
    end
    errs = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (rc0 + i < obs_q.size()) begin
        if (obs_q[rc0 + i] !== exp_q[i]) errs++;
      end else begin
        errs++;
      end
    end
    n_tests++;
    if (errs != 0) begin
      n_fail++; $display("FAIL rand_data: got %0d wrong bytes expected 0", errs);
    end
    n_tests++;
    if (fe_count - fe0 != fe_exp) begin
      n_fail++; $display("FAIL rand_fe: got %0d expected %0d", fe_count - fe0, fe_exp);
    end
    n_tests++;
    if (ov_count != ov0) begin
      n_fail++; $display("FAIL rand_ov: got %0d expected 0", ov_count - ov0);
    end
  endtask

  initial begin
    bus.data_out_ready = 1'b0;
    reset = 1'b1;
    serial_in = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
